// File: rtl/mips_unified_mem_pkg.sv
// mips_mem_pkg: shared state encoding and lane helpers for the unified memory
package mips_mem_pkg;
  typedef enum logic [1:0] {RUN, LOAD, CLEAR} state_t;
  localparam int BYTE_OFS = 2;
  function automatic int lanes(input int w);
    return w / 8;
  endfunction
endpackage

// File: rtl/mips_unified_mem_if.sv
// mips_unified_mem_if: core, loader and control signals of the unified memory
interface mips_unified_mem_if import mips_mem_pkg::*; #(parameter int DATA_W = 32, parameter int ADR_W = 32);
  logic [ADR_W-1:0] a;
  logic [DATA_W-1:0] wd;
  logic we;
  logic re;
  logic [lanes(DATA_W)-1:0] be;
  logic [DATA_W-1:0] rd;
  logic rd_valid;
  logic err;
  logic busy;
  logic load_req;
  logic load_valid;
  logic [ADR_W-1:0] load_adr;
  logic [DATA_W-1:0] load_data;
  logic load_ready;
  logic load_done;
  logic clr_req;
  logic [DATA_W-1:0] test_mem;
  modport master (
    output a, wd, we, re, be, load_req, load_valid, load_adr, load_data, clr_req,
    input rd, rd_valid, err, busy, load_ready, load_done, test_mem
  );
  modport slave (
    input a, wd, we, re, be, load_req, load_valid, load_adr, load_data, clr_req,
    output rd, rd_valid, err, busy, load_ready, load_done, test_mem
  );
endinterface

// File: rtl/mips_unified_mem_ctrl.sv
// mips_mem_ctrl: RUN/LOAD/CLEAR sequencer, clear counter and loader handshake
module mips_mem_ctrl import mips_mem_pkg::*; #(
  parameter int DEPTH = 256,
  localparam int CW = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic res,
  input  logic load_req,
  input  logic clr_req,
  output state_t state,
  output logic [CW-1:0] cnt,
  output logic busy,
  output logic load_ready,
  output logic load_done
);
  state_t nxt;
  always_comb begin
    nxt = state;
    nxt = state == RUN  ? (load_req ? LOAD : clr_req ? CLEAR : RUN)
        : state == LOAD ? (load_req ? LOAD : RUN)
        : (cnt == CW'(DEPTH - 1) ? RUN : CLEAR);
  end
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state <= RUN;
      cnt <= '0;
      busy <= 1'b0;
      load_done <= 1'b0;
    end else begin
      state <= nxt;
      cnt <= (state == CLEAR && nxt == CLEAR) ? cnt + 1'b1 : '0;
      busy <= nxt != RUN;
      load_done <= state == LOAD && nxt == RUN;
    end
  end
  assign load_ready = state == LOAD;
endmodule

// File: rtl/mips_unified_mem.sv
// mips_unified_mem: word-organised unified memory with byte enables, loader and clear
module mips_unified_mem import mips_mem_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int DEPTH = 256,
  parameter int ADR_W = 32,
  parameter int TEST_IDX = 11
) (
  input logic clk,
  input logic res,
  mips_unified_mem_if.slave bus
);
  localparam int NB = lanes(DATA_W);
  localparam int IW = $clog2(DEPTH);
  logic [DATA_W-1:0] mem [DEPTH];
  state_t state;
  logic [IW-1:0] cnt;
  logic [IW-1:0] idx;
  logic ok, access, hit, load_oob, load_we;
  always_comb begin
    ok = bus.a[BYTE_OFS-1:0] == '0 && ADR_W'(bus.a[ADR_W-1:BYTE_OFS]) < ADR_W'(DEPTH);
    idx = bus.a[BYTE_OFS +: IW];
    access = state == RUN && (bus.we || bus.re);
    hit = access && ok;
    load_oob = bus.load_adr >= ADR_W'(DEPTH);
    load_we = state == LOAD && bus.load_valid && !load_oob;
  end
  // Only one writer can be active per cycle since the sources are state-exclusive
  always_ff @(posedge clk) begin
    if (state == CLEAR) mem[cnt] <= '0;
    else if (load_we) mem[bus.load_adr[IW-1:0]] <= bus.load_data;
    else if (hit && bus.we)
      for (int i = 0; i < NB; i++)
        if (bus.be[i]) mem[idx][8*i +: 8] <= bus.wd[8*i +: 8];
  end
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      bus.rd <= '0;
      bus.rd_valid <= 1'b0;
      bus.err <= 1'b0;
    end else begin
      bus.rd_valid <= hit && bus.re;
      bus.err <= (access && !ok) || (state == LOAD && bus.load_valid && load_oob);
      if (hit && bus.re) bus.rd <= mem[idx];
    end
  end
  assign bus.test_mem = mem[TEST_IDX];
  mips_mem_ctrl #(.DEPTH(DEPTH)) u_ctrl (
    .clk(clk),
    .res(res),
    .load_req(bus.load_req),
    .clr_req(bus.clr_req),
    .state(state),
    .cnt(cnt),
    .busy(bus.busy),
    .load_ready(bus.load_ready),
    .load_done(bus.load_done)
  );
endmodule

// File: tb/tb_mips_unified_mem.sv
// tb_mips_unified_mem: directed vectors and multi-cycle sequences for mips_unified_mem
module tb_mips_unified_mem;
  localparam int DEPTH = 256;
  typedef struct {
    logic [31:0] a;
    logic [31:0] wd;
    logic we;
    logic re;
    logic [3:0] be;
    logic [31:0] rd;
    logic v;
    logic e;
  } vec_t;
  logic clk = 1'b0;
  logic res = 1'b0;
  int checks = 0;
  int failures = 0;
  vec_t vecs [18];
  mips_unified_mem_if #(.DATA_W(32), .ADR_W(32)) bus();
  mips_unified_mem #(.DATA_W(32), .DEPTH(DEPTH), .ADR_W(32), .TEST_IDX(11)) dut (
    .clk(clk),
    .res(res),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", n, act, exp);
    end
  endtask
  task automatic idle();
    bus.a = '0; bus.wd = '0; bus.we = 1'b0; bus.re = 1'b0; bus.be = '0;
    bus.load_req = 1'b0; bus.load_valid = 1'b0; bus.load_adr = '0; bus.load_data = '0;
    bus.clr_req = 1'b0;
  endtask
  task automatic core(input logic [31:0] a, input logic [31:0] wd, input logic we, input logic re, input logic [3:0] be);
    @(negedge clk);
    bus.a = a; bus.wd = wd; bus.we = we; bus.re = re; bus.be = be;
    @(posedge clk);
    #1;
    bus.we = 1'b0; bus.re = 1'b0;
  endtask
  task automatic beat(input logic [31:0] adr, input logic [31:0] data);
    @(negedge clk);
    bus.load_valid = 1'b1; bus.load_adr = adr; bus.load_data = data;
    @(posedge clk);
    #1;
    bus.load_valid = 1'b0;
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end
  initial begin
    logic [31:0] ladr [5];
    logic [31:0] ldat [5];
    logic [31:0] exp4 [4];
    int n, bad, ld;
    vecs[0]  = '{32'd0,    32'h0,        1'b0, 1'b1, 4'h0, 32'h11111111, 1'b1, 1'b0};
    vecs[1]  = '{32'd4,    32'h0,        1'b0, 1'b1, 4'h0, 32'h22222222, 1'b1, 1'b0};
    vecs[2]  = '{32'd8,    32'h0,        1'b0, 1'b1, 4'h0, 32'h33333333, 1'b1, 1'b0};
    vecs[3]  = '{32'd12,   32'h0,        1'b0, 1'b1, 4'h0, 32'h44444444, 1'b1, 1'b0};
    vecs[4]  = '{32'd8,    32'h44444444, 1'b1, 1'b0, 4'hF, 32'h44444444, 1'b0, 1'b0};
    vecs[5]  = '{32'd8,    32'hAABBCCDD, 1'b1, 1'b0, 4'h5, 32'h44444444, 1'b0, 1'b0};
    vecs[6]  = '{32'd8,    32'h0,        1'b0, 1'b1, 4'h0, 32'h44BB44DD, 1'b1, 1'b0};
    vecs[7]  = '{32'd6,    32'h0,        1'b0, 1'b1, 4'h0, 32'h44BB44DD, 1'b0, 1'b1};
    vecs[8]  = '{32'd1024, 32'h12345678, 1'b1, 1'b0, 4'hF, 32'h44BB44DD, 1'b0, 1'b1};
    vecs[9]  = '{32'd0,    32'h0,        1'b0, 1'b1, 4'h0, 32'h11111111, 1'b1, 1'b0};
    vecs[10] = '{32'd0,    32'hDEADBEEF, 1'b1, 1'b1, 4'hF, 32'h11111111, 1'b1, 1'b0};
    vecs[11] = '{32'd0,    32'h0,        1'b0, 1'b1, 4'h0, 32'hDEADBEEF, 1'b1, 1'b0};
    vecs[12] = '{32'd0,    32'h0,        1'b0, 1'b0, 4'h0, 32'hDEADBEEF, 1'b0, 1'b0};
    vecs[13] = '{32'd44,   32'hCAFEF00D, 1'b1, 1'b0, 4'hF, 32'hDEADBEEF, 1'b0, 1'b0};
    vecs[14] = '{32'd44,   32'h0,        1'b0, 1'b1, 4'h0, 32'hCAFEF00D, 1'b1, 1'b0};
    vecs[15] = '{32'd1024, 32'h0,        1'b0, 1'b1, 4'h0, 32'hCAFEF00D, 1'b0, 1'b1};
    vecs[16] = '{32'd1020, 32'h0BADCAFE, 1'b1, 1'b0, 4'hF, 32'hCAFEF00D, 1'b0, 1'b0};
    vecs[17] = '{32'd1020, 32'h0,        1'b0, 1'b1, 4'h0, 32'h0BADCAFE, 1'b1, 1'b0};
    ladr = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd256};
    ldat = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'h99999999};
    idle();
    #12;
    chk("reset_rd", bus.rd, 32'h0);
    chk("reset_rd_valid", 32'(bus.rd_valid), 32'h0);
    chk("reset_err", 32'(bus.err), 32'h0);
    chk("reset_busy", 32'(bus.busy), 32'h0);
    chk("reset_load_done", 32'(bus.load_done), 32'h0);
    chk("reset_load_ready", 32'(bus.load_ready), 32'h0);
    @(negedge clk);
    res = 1'b1;
    @(negedge clk);
    bus.load_req = 1'b1;
    @(posedge clk);
    #1;
    chk("load_busy", 32'(bus.busy), 32'h1);
    chk("load_ready", 32'(bus.load_ready), 32'h1);
    bus.a = 32'd6;
    bus.re = 1'b1;
    for (int i = 0; i < 5; i++) begin
      beat(ladr[i], ldat[i]);
      chk($sformatf("load_err%0d", i), 32'(bus.err), (i == 4) ? 32'h1 : 32'h0);
      chk($sformatf("load_rd_valid%0d", i), 32'(bus.rd_valid), 32'h0);
    end
    @(negedge clk);
    bus.load_req = 1'b0;
    bus.re = 1'b0;
    bus.a = '0;
    @(posedge clk);
    #1;
    chk("load_done_pulse", 32'(bus.load_done), 32'h1);
    chk("load_exit_busy", 32'(bus.busy), 32'h0);
    chk("load_exit_ready", 32'(bus.load_ready), 32'h0);
    @(posedge clk);
    #1;
    chk("load_done_single", 32'(bus.load_done), 32'h0);
    for (int i = 0; i < 18; i++) begin
      core(vecs[i].a, vecs[i].wd, vecs[i].we, vecs[i].re, vecs[i].be);
      chk($sformatf("vec%0d_rd", i), bus.rd, vecs[i].rd);
      chk($sformatf("vec%0d_rd_valid", i), 32'(bus.rd_valid), 32'(vecs[i].v));
      chk($sformatf("vec%0d_err", i), 32'(bus.err), 32'(vecs[i].e));
    end
    chk("test_mem_before_clear", bus.test_mem, 32'hCAFEF00D);
    @(negedge clk);
    bus.clr_req = 1'b1;
    @(posedge clk);
    #1;
    bus.clr_req = 1'b0;
    bus.a = '0; bus.wd = 32'hFFFFFFFF; bus.be = 4'hF; bus.we = 1'b1; bus.re = 1'b1;
    bus.load_req = 1'b0;
    n = 0;
    bad = 0;
    while (bus.busy && n < DEPTH + 8) begin
      n++;
      if (bus.rd_valid || bus.err) bad++;
      @(posedge clk);
      #1;
    end
    bus.we = 1'b0;
    bus.re = 1'b0;
    chk("clear_busy_cycles", 32'(n), 32'(DEPTH));
    chk("clear_core_ignored", 32'(bad), 32'h0);
    chk("clear_test_mem", bus.test_mem, 32'h0);
    bad = 0;
    for (int w = 0; w < DEPTH; w++) begin
      core(32'(4 * w), 32'h0, 1'b0, 1'b1, 4'h0);
      if (bus.rd !== 32'h0 || bus.rd_valid !== 1'b1) bad++;
    end
    chk("clear_all_words_zero", 32'(bad), 32'h0);
    core(32'd8, 32'h55555555, 1'b1, 1'b0, 4'hF);
    core(32'd12, 32'h66666666, 1'b1, 1'b0, 4'hF);
    @(negedge clk);
    bus.load_req = 1'b1;
    @(posedge clk);
    #1;
    beat(32'd0, 32'hA0A0A0A0);
    beat(32'd1, 32'hA1A1A1A1);
    @(negedge clk);
    res = 1'b0;
    #1;
    chk("midload_reset_busy", 32'(bus.busy), 32'h0);
    chk("midload_reset_ready", 32'(bus.load_ready), 32'h0);
    chk("midload_reset_done", 32'(bus.load_done), 32'h0);
    chk("midload_reset_rd", bus.rd, 32'h0);
    @(negedge clk);
    bus.load_req = 1'b0;
    res = 1'b1;
    ld = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      if (bus.load_done) ld++;
    end
    chk("midload_no_done", 32'(ld), 32'h0);
    exp4 = '{32'hA0A0A0A0, 32'hA1A1A1A1, 32'h55555555, 32'h66666666};
    for (int w = 0; w < 4; w++) begin
      core(32'(4 * w), 32'h0, 1'b0, 1'b1, 4'h0);
      chk($sformatf("midload_word%0d", w), bus.rd, exp4[w]);
      chk($sformatf("midload_valid%0d", w), 32'(bus.rd_valid), 32'h1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
